// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds a source of the
// instruction in ID. Writes to r0 never create a dependency.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);

    always_comb begin
        lu = ex_mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use bubbles, MEM-stage branch flushes and
// multi-cycle data-memory waits with timeout. Mealy outputs from state + inputs.
//
// state    | meaning
// RUN      | pipeline advancing; hazards resolved by priority
// MEM_WAIT | data memory access outstanding, whole pipeline frozen
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_W = 4,
    parameter int TIMEOUT   = 12,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic [1:0]       mem_mem,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             dmem_req,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [TIMEOUT_W-1:0] TO_VAL  = TIMEOUT_W'(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] CNT_ZERO = '0;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    logic mem_op, br, lu, stall;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .lu          (lu)
    );

    assign mem_op = mem_mem[MEM_RD] | mem_mem[MEM_WR];
    assign br     = mem_branch & mem_zero;

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        dmem_req      = mem_op;
        stall         = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            RUN: begin
                // A nonzero count in RUN marks the cycle after a timeout:
                // the abandoned op is still sitting in EX/MEM and is killed here.
                if (wait_cnt_q != CNT_ZERO) begin
                    exmem_flush = 1'b1;
                    wait_cnt_d  = CNT_ZERO;
                end else if (mem_op && !dmem_ready) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_en    = 1'b0;
                    memwb_flush = 1'b1;
                    stall       = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = CNT_ONE;
                end else if (br) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    stall      = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_en    = 1'b0;
                memwb_flush = 1'b1;
                stall       = 1'b1;
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = CNT_ZERO;
                end else if (wait_cnt_q == TO_VAL) begin
                    timeout_err_d = 1'b1;
                    state_d       = RUN;
                    wait_cnt_d    = TO_VAL;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = CNT_ZERO;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Reset holds every stage register in bubble regardless of state.
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            dmem_req    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign timeout_err = timeout_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; stall counter narrowed to 5 bits so
// saturation is reachable in a short run.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             ex_mem_read;
    logic [1:0]       mem_mem;
    logic             mem_branch, mem_zero, dmem_ready;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic             dmem_req, timeout_err;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes, dmem_req}
    localparam logic [9:0] V_RST   = 10'b00000_1111_0;
    localparam logic [9:0] V_IDLE  = 10'b11111_0000_0;
    localparam logic [9:0] V_LU    = 10'b00111_0100_0;
    localparam logic [9:0] V_BR    = 10'b11111_1110_0;
    localparam logic [9:0] V_MSTL  = 10'b00000_0001_1;
    localparam logic [9:0] V_ZW    = 10'b11111_0000_1;
    localparam logic [9:0] V_KILL  = 10'b11111_0010_1;

    logic [9:0] ctl;
    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req};

    pipe_hazard_ctrl #(.TIMEOUT_W(4), .TIMEOUT(12), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .mem_mem     (mem_mem),
        .mem_branch  (mem_branch),
        .mem_zero    (mem_zero),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .dmem_req    (dmem_req),
        .timeout_err (timeout_err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; ex_mem_read = 1'b0;
        mem_mem = 2'b00; mem_branch = 1'b0; mem_zero = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs change on the falling edge, outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #3;
        chk("reset_ctl", 32'(ctl), 32'(V_RST));
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_to", 32'(timeout_err), 32'd0);

        next_cycle();
        rst = 1'b1;
        #1 chk("idle_ctl", 32'(ctl), 32'(V_IDLE));

        // load-use on rs
        next_cycle();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd7;
        #1 chk("lu_ctl", 32'(ctl), 32'(V_LU));
        next_cycle();
        idle_inputs();
        #1 chk("lu_after_ctl", 32'(ctl), 32'(V_IDLE));
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // load to r0 is never a hazard
        next_cycle();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 chk("lu_r0_ctl", 32'(ctl), 32'(V_IDLE));

        // load-use via rt operand combined with taken branch: branch wins
        next_cycle();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9;
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1 chk("br_ctl", 32'(ctl), 32'(V_BR));
        chk("br_precnt", 32'(stall_cnt), 32'd1);

        next_cycle();
        idle_inputs();
        mem_branch = 1'b1; mem_zero = 1'b0;
        #1 chk("br_nt_ctl", 32'(ctl), 32'(V_IDLE));
        chk("br_cnt", 32'(stall_cnt), 32'd1);

        // memory wait: ready low for 3 cycles, then high
        next_cycle();
        idle_inputs();
        mem_mem = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_ctl%0d", i), 32'(ctl), 32'(V_MSTL));
            next_cycle();
        end
        dmem_ready = 1'b1;
        #1 chk("mw_ready_ctl", 32'(ctl), 32'(V_MSTL));
        next_cycle();
        idle_inputs();
        #1 chk("mw_after_ctl", 32'(ctl), 32'(V_IDLE));
        chk("mw_cnt", 32'(stall_cnt), 32'd5);

        // zero-wait write
        next_cycle();
        mem_mem = 2'b01; dmem_ready = 1'b1;
        #1 chk("zw_ctl", 32'(ctl), 32'(V_ZW));
        next_cycle();
        idle_inputs();
        #1 chk("zw_cnt", 32'(stall_cnt), 32'd5);

        // timeout: one RUN stall cycle plus 12 MEM_WAIT cycles
        next_cycle();
        mem_mem = 2'b10; dmem_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            #1 chk($sformatf("to_stall%0d", i), 32'(ctl), 32'(V_MSTL));
            if (i == 12) chk("to_not_yet", 32'(timeout_err), 32'd0);
            next_cycle();
        end
        #1 chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_kill_ctl", 32'(ctl), 32'(V_KILL));
        chk("to_cnt", 32'(stall_cnt), 32'd18);

        // keep the op stuck: another 13 stalls reach 31, then a kill, then saturation
        for (int i = 0; i < 20; i++) next_cycle();
        #1 chk("sat_cnt", 32'(stall_cnt), 32'd31);
        chk("to_sticky", 32'(timeout_err), 32'd1);
        chk("mid_wait_ctl", 32'(ctl), 32'(V_MSTL));

        // asynchronous reset in the middle of a wait
        #2 rst = 1'b0;
        #1 chk("rst_mid_ctl", 32'(ctl), 32'(V_RST));
        chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mid_to", 32'(timeout_err), 32'd0);

        next_cycle();
        idle_inputs();
        rst = 1'b1;
        #1 chk("post_rst_ctl", 32'(ctl), 32'(V_IDLE));
        next_cycle();
        mem_mem = 2'b10; dmem_ready = 1'b1;
        #1 chk("post_rst_run", 32'(ctl), 32'(V_ZW));
        next_cycle();
        idle_inputs();
        #1 chk("post_rst_cnt", 32'(stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
